secded_stream_decoder: RTL and testbench
========================================

// Module: secded_stream_decoder
// PURPOSE
//  Parametrised, pipelined successor to the combinational 12->7 syndrome decoder.
//  - Takes systematic codewords on a valid/ready stream: data in cx[K-1:0], parity in cx[N-1:K].
//  - Computes the syndrome and corrects any single-bit error located by an H-matrix column.
//  - Flags uncorrectable syndromes and keeps saturating error-statistics counters.
//  - Sits between the channel deserialiser and the payload sink.
// PARAMETERS
//  N      12   codeword width
//  K      7    data width; R = N-K parity/syndrome bits
//  H_COLS 60'h (default below)   N columns of R bits, flattened; column j = H_COLS[j*R +: R]
//         default cols 0..11: 03,05,06,09,0A,0C,11,01,02,04,08,10 (parity cols one-hot)
//  CNT_W  16   statistics counter width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      cx valid
//  in_ready   out  1      decoder accepts cx this cycle
//  cx         in   N      received codeword
//  correct_en in   1      1: correct single errors; 0: detect-only; sampled with cx
//  out_valid  out  1      d and flags valid
//  out_ready  in   1      sink accepts this cycle
//  d          out  K      decoded data
//  err_corr   out  1      single error located (data or parity bit)
//  err_uncorr out  1      nonzero syndrome matching no column
//  cnt_corr   out  CNT_W  saturating count of delivered err_corr words
//  cnt_uncorr out  CNT_W  saturating count of delivered err_uncorr words
//  cnt_clr    in   1      synchronous clear of both counters
// BEHAVIOUR
//  - Reset: every register 0; in_ready=1 and all other outputs 0 while rst_n=0 and one cycle after.
//  - Pipeline, two stages:
//      S1 registers cx, correct_en and syndrome S = XOR of H columns j where cx[j]=1.
//      S2 registers d, err_corr, err_uncorr.
//  - Latency: 2 cycles from an in handshake to out_valid when there is no stall.
//  - Throughput: 1 word/cycle.
//  - Stage advance rules:
//      S2 loads when !out_valid || out_ready.
//      S1 loads when !s1_valid || S2 loads.
//      in_ready = !s1_valid || S2 loads (combinational from out_ready; no bubble).
//  - Stall: while out_valid && !out_ready, d and both flags hold stable.
//      No word is dropped or duplicated.
//  - Decode:
//      S==0: d=cx[K-1:0], flags 0.
//      S==col j, j<K: err_corr=1; d=cx[K-1:0] with bit j flipped if correct_en, else raw.
//      S==col j, j>=K: err_corr=1; d raw (parity-only error).
//      S nonzero, no match: err_uncorr=1; d raw.
//      err_corr and err_uncorr are never both 1.
//  - Columns must be distinct and nonzero; behaviour with duplicate columns is undefined.
//  - Counters:
//      Increment on the out handshake (out_valid && out_ready) when the matching flag is 1.
//      Saturate at all-ones.
//      cnt_clr in the same cycle as an increment: clear wins; counter = 0.
//  - Reset mid-stream: in-flight words are discarded; counters return to 0.
// STRUCTURE
//  - Shared package dec_pkg: default H_COLS constant, function syndrome(cx,H), function locate(S,H)
//    returning {hit, index}.
//  - One sub-module, dec_pipe_stage: a valid/ready register slice, instantiated twice with
//    different payload widths.
//  - Counters inline.
// TESTING (default parameters, correct_en=1, out_ready=1 unless stated)
//  1. cx=12'h181 (d=1, clean) -> d=7'h01, flags 0, out_valid exactly 2 cycles after the in handshake.
//  2. cx=12'h189 (bit3 flipped) -> S=0x09; d=7'h01, err_corr=1, cnt_corr=1.
//     Same word with correct_en=0 -> d=7'h09, err_corr=1.
//  3. cx=12'h800 (parity bit11) -> S=0x10; d=7'h00, err_corr=1.
//     cx=12'h380 -> S=0x07; err_uncorr=1, d=7'h00, cnt_uncorr=1.
//  4. Back-to-back 8 words while out_ready toggles 1,0,0,1...
//     -> sequence delivered in order, none lost or repeated; d stable across stalls;
//        in_ready low only while both stages are full and stalled.
//  5. Preload cnt_corr to 16'hFFFF, then send a correctable word -> stays 16'hFFFF.
//     cnt_clr coincident with a correctable handshake -> cnt_corr=0.
//  6. Assert rst_n=0 with 2 words in flight
//     -> out_valid=0 and counters 0 immediately (async); no stale word after release.

Source files
------------

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared constants, types and syndrome/locate helpers for the stream decoder
//
// Purpose: default 12/7 H matrix, a fixed-stride H matrix type and the two pure
// functions used by the decoder pipeline.
//   syndrome(cx, h) : XOR of the H columns selected by the set bits of cx
//   locate(s, h)    : {hit, index} of the column equal to a nonzero syndrome
// No ports (package).
package dec_pkg;

    // Upper bounds that the fixed-stride helper types are sized for.
    localparam int MAX_N = 32;
    localparam int MAX_R = 8;
    localparam int IDX_W = $clog2(MAX_N);

    localparam int DEF_N = 12;
    localparam int DEF_K = 7;
    localparam int DEF_R = DEF_N - DEF_K;

    // Columns 11..0; data columns 0..6, one-hot parity columns 7..11.
    localparam logic [DEF_N*DEF_R-1:0] DEF_H_COLS = {
        5'h10, 5'h08, 5'h04, 5'h02, 5'h01,
        5'h11, 5'h0C, 5'h0A, 5'h09, 5'h06, 5'h05, 5'h03
    };

    // One MAX_R-wide slot per column; slots beyond N stay zero.
    typedef logic [MAX_N-1:0][MAX_R-1:0] hmat_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } loc_t;

    function automatic logic [MAX_R-1:0] syndrome(input logic [MAX_N-1:0] cx, input hmat_t h);
        logic [MAX_R-1:0] s;
        s = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if (cx[j]) begin
                s = s ^ h[j];
            end
        end
        return s;
    endfunction

    // Unused slots are zero and a zero syndrome never matches, so no column
    // count is needed here.
    function automatic loc_t locate(input logic [MAX_R-1:0] s, input hmat_t h);
        loc_t r;
        r = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if (!r.hit && (s != '0) && (h[j] == s)) begin
                r.hit = 1'b1;
                r.idx = IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/secded_stream_decoder_if.sv
// rtl/secded_stream_decoder_if.sv - codeword-in / data-out stream bundle of the decoder
//
// Purpose: groups both valid/ready streams of the decoder.
//   in side : in_valid, in_ready, cx[N], correct_en
//   out side: out_valid, out_ready, d[K], err_corr, err_uncorr
// Modports: master = producer/consumer side (bench, channel), slave = decoder.
interface secded_stream_decoder_if
    import dec_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] cx;
    logic         correct_en;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] d;
    logic         err_corr;
    logic         err_uncorr;

    modport master (
        output in_valid, cx, correct_en, out_ready,
        input  in_ready, out_valid, d, err_corr, err_uncorr
    );

    modport slave (
        input  in_valid, cx, correct_en, out_ready,
        output in_ready, out_valid, d, err_corr, err_uncorr
    );
endinterface

// File: rtl/dec_pipe_stage.sv
// rtl/dec_pipe_stage.sv - one valid/ready register slice
//
// Purpose: holds one W-bit word; accepts a new one whenever it is empty or its
// current word leaves this cycle, so a chain of slices runs at 1 word/cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready combinational from out_ready)
//   in_data[W]           upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data[W]          registered payload, held while stalled
module dec_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/secded_stream_decoder.sv
// rtl/secded_stream_decoder.sv - two-stage pipelined single-error-correcting stream decoder
//
// Purpose: decodes systematic codewords (data cx[K-1:0], parity cx[N-1:K]) arriving
// on a valid/ready stream, corrects single errors located by an H column, flags
// uncorrectable syndromes and counts delivered corrected/uncorrectable words.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   io (slave)        in_valid/in_ready/cx/correct_en -> out_valid/out_ready/d/err_corr/err_uncorr
//   cnt_clr           synchronous clear of both counters (wins over increment)
//   cnt_corr          saturating count of delivered err_corr words
//   cnt_uncorr        saturating count of delivered err_uncorr words
module secded_stream_decoder
    import dec_pkg::*;
#(
    parameter int                 N      = DEF_N,
    parameter int                 K      = DEF_K,
    parameter logic [(N-K)*N-1:0] H_COLS = DEF_H_COLS,
    parameter int                 CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    secded_stream_decoder_if.slave io,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       cnt_corr,
    output logic [CNT_W-1:0]       cnt_uncorr
);

    localparam int R  = N - K;
    // S1 keeps only the data bits of cx: parity is fully summarised by the syndrome.
    localparam int W1 = 1 + K + MAX_R;
    localparam int W2 = K + 2;

    function automatic hmat_t expand_h();
        hmat_t m;
        m = '0;
        for (int j = 0; j < N; j++) begin
            m[j] = MAX_R'(H_COLS[j*R +: R]);
        end
        return m;
    endfunction

    localparam hmat_t H = expand_h();

    // Stage 1: syndrome computed on the incoming word, registered with data and mode.
    logic [MAX_R-1:0] syn_in;
    logic [W1-1:0]    s1_in;
    logic [W1-1:0]    s1_q;
    logic             s1_valid;
    logic             s2_in_ready;
    logic             s1_ce;
    logic [K-1:0]     s1_data;
    logic [MAX_R-1:0] s1_syn;

    assign syn_in = syndrome(MAX_N'(io.cx), H);
    assign s1_in  = {io.correct_en, io.cx[K-1:0], syn_in};
    assign {s1_ce, s1_data, s1_syn} = s1_q;

    dec_pipe_stage #(.W(W1)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (io.in_valid),
        .in_ready  (io.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Stage 2: locate the syndrome and build corrected data plus flags.
    loc_t          loc;
    logic [K-1:0]  d_fix;
    logic          corr;
    logic          uncorr;
    logic [W2-1:0] s2_q;

    always_comb begin
        loc    = locate(s1_syn, H);
        d_fix  = s1_data;
        corr   = 1'b0;
        uncorr = 1'b0;
        if (loc.hit) begin
            corr = 1'b1;
            // Parity-column hits (index >= K) leave the data untouched.
            for (int b = 0; b < K; b++) begin
                if (s1_ce && (int'(loc.idx) == b)) begin
                    d_fix[b] = ~s1_data[b];
                end
            end
        end else if (s1_syn != '0) begin
            uncorr = 1'b1;
        end
    end

    dec_pipe_stage #(.W(W2)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({d_fix, corr, uncorr}),
        .out_valid (io.out_valid),
        .out_ready (io.out_ready),
        .out_data  (s2_q)
    );

    assign {io.d, io.err_corr, io.err_uncorr} = s2_q;

    // Statistics count words as they leave, not as they are decoded.
    logic out_hs;
    assign out_hs = io.out_valid && io.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (out_hs && io.err_corr && (cnt_corr != '1)) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (out_hs && io.err_uncorr && (cnt_uncorr != '1)) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb/tb_secded_stream_decoder.sv - directed table-driven bench for secded_stream_decoder
module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_uncorr;
    logic        sat_clr = 1'b0;
    logic [2:0]  sat_corr;
    logic [2:0]  sat_uncorr;

    always #5 clk = ~clk;

    secded_stream_decoder_if #(.N(12), .K(7)) sio ();
    secded_stream_decoder_if #(.N(12), .K(7)) ssio ();

    secded_stream_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (sio),
        .cnt_clr    (cnt_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    secded_stream_decoder #(.CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (ssio),
        .cnt_clr    (sat_clr),
        .cnt_corr   (sat_corr),
        .cnt_uncorr (sat_uncorr)
    );

    typedef struct {
        logic [11:0] cx;
        logic        ce;
        logic [6:0]  d;
        logic        ec;
        logic        eu;
    } vec_t;

    vec_t vecs [13];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_c = 0;
    int   exp_u = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with out_ready=1; returns at a negedge after the
    // output handshake has landed.
    task automatic xfer(input logic [11:0] c, input logic ce, output logic [6:0] d_o,
                        output logic ec_o, output logic eu_o, output int lat, output logic dup);
        int w;
        sio.cx = c;
        sio.correct_en = ce;
        sio.in_valid = 1'b1;
        w = 0;
        #1;
        while (!sio.in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        sio.in_valid = 1'b0;
        lat = 1;
        while (!sio.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d_o  = sio.d;
        ec_o = sio.err_corr;
        eu_o = sio.err_uncorr;
        @(posedge clk);
        #1;
        dup = sio.out_valid;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] d_o;
        logic       ec_o, eu_o, dup;
        int         lat, sent, rcvd, occ, stale;
        logic       prev_stall;
        logic [8:0] prev_word;

        vecs[0]  = '{12'h181, 1'b1, 7'h01, 1'b0, 1'b0};
        vecs[1]  = '{12'h189, 1'b1, 7'h01, 1'b1, 1'b0};
        vecs[2]  = '{12'h189, 1'b0, 7'h09, 1'b1, 1'b0};
        vecs[3]  = '{12'h800, 1'b1, 7'h00, 1'b1, 1'b0};
        vecs[4]  = '{12'h380, 1'b1, 7'h00, 1'b0, 1'b1};
        vecs[5]  = '{12'hF55, 1'b1, 7'h55, 1'b0, 1'b0};
        vecs[6]  = '{12'hF15, 1'b1, 7'h55, 1'b1, 1'b0};
        vecs[7]  = '{12'hF56, 1'b1, 7'h52, 1'b1, 1'b0};
        vecs[8]  = '{12'hD55, 1'b1, 7'h55, 1'b1, 1'b0};
        vecs[9]  = '{12'hF14, 1'b1, 7'h14, 1'b0, 1'b1};
        vecs[10] = '{12'hFFF, 1'b1, 7'h7F, 1'b1, 1'b0};
        vecs[11] = '{12'hF54, 1'b0, 7'h54, 1'b1, 1'b0};
        vecs[12] = '{12'h000, 1'b1, 7'h00, 1'b0, 1'b0};

        sio.in_valid = 1'b0;
        sio.cx = '0;
        sio.correct_en = 1'b1;
        sio.out_ready = 1'b1;
        ssio.in_valid = 1'b0;
        ssio.cx = '0;
        ssio.correct_en = 1'b1;
        ssio.out_ready = 1'b1;

        // Reset state, during reset and one cycle after release.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", sio.in_ready, 1);
        chk("rst_out_valid", sio.out_valid, 0);
        chk("rst_outs", {sio.d, sio.err_corr, sio.err_uncorr}, 0);
        chk("rst_cnts", {cnt_corr, cnt_uncorr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", sio.in_ready, 1);
        chk("post_rst_out_valid", sio.out_valid, 0);
        @(negedge clk);

        // Table: one word at a time, fixed 2-cycle latency.
        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].cx, vecs[i].ce, d_o, ec_o, eu_o, lat, dup);
            exp_c += int'(vecs[i].ec);
            exp_u += int'(vecs[i].eu);
            chk($sformatf("vec%0d_d", i), d_o, vecs[i].d);
            chk($sformatf("vec%0d_err_corr", i), ec_o, vecs[i].ec);
            chk($sformatf("vec%0d_err_uncorr", i), eu_o, vecs[i].eu);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_no_dup", i), dup, 0);
            chk($sformatf("vec%0d_cnt_corr", i), cnt_corr, exp_c);
            chk($sformatf("vec%0d_cnt_uncorr", i), cnt_uncorr, exp_u);
        end

        // Back-to-back 8 words with out_ready pattern 1,0,0 repeating.
        sent = 0;
        rcvd = 0;
        occ = 0;
        prev_stall = 1'b0;
        prev_word = '0;
        for (int cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
            int acc, del;
            sio.out_ready = ((cyc % 3) == 0);
            sio.in_valid = (sent < 8);
            if (sent < 8) begin
                sio.cx = vecs[sent].cx;
                sio.correct_en = vecs[sent].ce;
            end
            #1;
            if (prev_stall) begin
                chk("stall_hold", {sio.d, sio.err_corr, sio.err_uncorr}, prev_word);
            end
            chk("stream_in_ready", sio.in_ready, !(occ == 2 && !sio.out_ready));
            acc = (sio.in_valid && sio.in_ready) ? 1 : 0;
            del = (sio.out_valid && sio.out_ready) ? 1 : 0;
            if (del == 1) begin
                chk($sformatf("stream%0d_word", rcvd), {sio.d, sio.err_corr, sio.err_uncorr},
                    {vecs[rcvd].d, vecs[rcvd].ec, vecs[rcvd].eu});
                exp_c += int'(vecs[rcvd].ec);
                exp_u += int'(vecs[rcvd].eu);
                rcvd++;
            end
            sent += acc;
            occ = occ + acc - del;
            prev_stall = sio.out_valid && !sio.out_ready;
            prev_word = {sio.d, sio.err_corr, sio.err_uncorr};
            @(negedge clk);
        end
        sio.in_valid = 1'b0;
        sio.out_ready = 1'b1;
        chk("stream_delivered", rcvd, 8);
        @(negedge clk);
        #1;
        chk("stream_drained", sio.out_valid, 0);
        chk("stream_cnt_corr", cnt_corr, exp_c);
        chk("stream_cnt_uncorr", cnt_uncorr, exp_u);
        @(negedge clk);

        // Saturation on a 3-bit counter instance: 9 correctable words -> all-ones.
        ssio.cx = 12'h189;
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 9; cyc++) begin
            ssio.in_valid = (sent < 9);
            #1;
            if (ssio.in_valid && ssio.in_ready) sent++;
            if (ssio.out_valid && ssio.out_ready) rcvd++;
            @(negedge clk);
        end
        ssio.in_valid = 1'b0;
        chk("sat_delivered", rcvd, 9);
        chk("sat_cnt_corr", sat_corr, 3'h7);
        chk("sat_cnt_uncorr", sat_uncorr, 0);

        // cnt_clr coincident with a correctable handshake: clear wins.
        sio.cx = 12'h189;
        sio.correct_en = 1'b1;
        sio.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sio.in_valid = 1'b0;
        lat = 0;
        while (!sio.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        chk("clr_word_valid", sio.out_valid && sio.out_ready && sio.err_corr, 1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_cnt_corr", cnt_corr, 0);
        chk("clr_cnt_uncorr", cnt_uncorr, 0);

        // Reset with two words in flight.
        xfer(12'h189, 1'b1, d_o, ec_o, eu_o, lat, dup);
        chk("pre_rst_cnt_corr", cnt_corr, 1);
        sio.out_ready = 1'b0;
        sio.in_valid = 1'b1;
        sio.cx = 12'h380;
        @(negedge clk);
        sio.cx = 12'h181;
        @(negedge clk);
        sio.in_valid = 1'b0;
        #1;
        chk("full_stall_in_ready", sio.in_ready, 0);
        chk("full_stall_out_valid", sio.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", sio.out_valid, 0);
        chk("async_rst_cnts", {cnt_corr, cnt_uncorr}, 0);
        chk("async_rst_in_ready", sio.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        sio.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (sio.out_valid) stale++;
            @(negedge clk);
        end
        chk("no_stale_after_rst", stale, 0);
        xfer(12'h181, 1'b1, d_o, ec_o, eu_o, lat, dup);
        chk("post_rst_word", {d_o, ec_o, eu_o}, {7'h01, 1'b0, 1'b0});
        chk("post_rst_latency", lat, 2);
        chk("post_rst_cnts", {cnt_corr, cnt_uncorr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
